// File: rtl/mult_pkg.sv
// Shared encodings for the sequential Booth multiplier.
// No logic: state enum and radix-2 Booth pair codes only.
// No flow control.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // {q0, q-1} pairs that require an add or subtract of the multiplicand
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/dffe_ref.sv
// Single-bit flop with enable and asynchronous active-high clear.
// Latency: 1 clock when enabled.
// No flow control.
module dffe_ref (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg65.sv
// Product register {hi, lo, q-1} built as one enabled flop per bit.
// Latency: 1 clock when enabled.
// No flow control; holds while en is low.
module reg65 #(
    parameter int N = 65
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        dffe_ref u_bit (
            .clk (clk),
            .clr (clr),
            .en  (en),
            .d   (d[i]),
            .q   (q[i])
        );
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// Latency: WIDTH clocks from the start edge; result_rdy pulses for one cycle afterwards.
// No backpressure: start is ignored while busy, the result is held until the next start.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    p_d;
    logic             start;
    logic             p_en;
    logic [1:0]       pair;
    logic             sub;
    logic             add_en;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   m_opnd;
    logic [WIDTH:0]   u;

    assign start  = ctrl_mult && (state != S_RUN);
    assign p_en   = start || (state == S_RUN);

    // One WIDTH+1-bit adder: subtract is invert plus carry-in. The extra bit keeps
    // M = -2^(WIDTH-1) from wrapping when it is negated.
    assign pair   = p_q[1:0];
    assign sub    = (pair == PAIR_SUB);
    assign add_en = (pair == PAIR_ADD) || sub;
    assign hi_ext = {p_q[PW-1], p_q[PW-1:WIDTH+1]};
    assign m_opnd = add_en ? ({m_reg[WIDTH-1], m_reg} ^ {(WIDTH+1){sub}}) : '0;
    assign u      = hi_ext + m_opnd + {{WIDTH{1'b0}}, sub};

    assign p_d    = start ? {{WIDTH{1'b0}}, operand_b, 1'b0} : {u, p_q[WIDTH:1]};

    reg65 #(
        .N (PW)
    ) u_preg (
        .clk (clk),
        .clr (~reset),
        .en  (p_en),
        .d   (p_d),
        .q   (p_q)
    );

    assign result    = p_q[WIDTH:1];
    assign result_hi = p_q[PW-1:WIDTH+1];
    // Fits in WIDTH signed bits only if the high word matches the low word's sign
    assign overflow  = !((&p_q[PW-1:WIDTH]) || !(|p_q[PW-1:WIDTH]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            m_reg      <= '0;
            count      <= '0;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        result_rdy <= 1'b1;
                    end
                end
                default: begin
                    result_rdy <= 1'b0;
                    if (ctrl_mult) begin
                        state <= S_RUN;
                        m_reg <= operand_a;
                        count <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
